// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the byte-wide Ethernet frame transmitter.
package eth_tx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_PREAMBLE = 4'd1,
    ST_SFD      = 4'd2,
    ST_DADDR    = 4'd3,
    ST_SADDR    = 4'd4,
    ST_LENTYPE  = 4'd5,
    ST_DATA     = 4'd6,
    ST_PAD      = 4'd7,
    ST_FCS      = 4'd8,
    ST_IFG      = 4'd9
  } eth_st_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam int          HDR_BYTES     = 14;
  localparam int          FCS_BYTES     = 4;

  typedef struct packed {
    logic [47:0] daddr;
    logic [47:0] saddr;
    logic [15:0] lentype;
  } eth_hdr_t;

  // Header byte idx in wire order: daddr MSB first, then saddr, then length/type.
  function automatic logic [7:0] hdr_byte(input eth_hdr_t h, input int idx);
    logic [8*HDR_BYTES-1:0] v;
    v = h;
    return v[8*(HDR_BYTES-1-idx) +: 8];
  endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// Byte-serial reflected CRC-32 (IEEE 802.3); ocrc is already final-XORed.
module eth_crc32_byte
  import eth_tx_pkg::*;
(
  input  logic        iclk,
  input  logic        irst,
  input  logic        iinit,
  input  logic        ien,
  input  logic [7:0]  idata,
  output logic [31:0] ocrc
);

  logic [31:0] crc_q, crc_d, nxt;

  always_comb begin
    nxt = crc_q ^ {24'h0, idata};
    for (int i = 0; i < 8; i++)
      nxt = nxt[0] ? ((nxt >> 1) ^ CRC_POLY_REFL) : (nxt >> 1);
    crc_d = crc_q;
    if (iinit)    crc_d = CRC_INIT;
    else if (ien) crc_d = nxt;
  end

  always_ff @(posedge iclk) begin
    if (irst) crc_q <= CRC_INIT;
    else      crc_q <= crc_d;
  end

  assign ocrc = ~crc_q;

endmodule

// File: rtl/eth_frame_tx_param.sv
// Ethernet frame transmitter: preamble/SFD, header, payload, pad, FCS, IFG.
// All outputs are registered; state_q is the state of the byte now on obyte.
module eth_frame_tx_param
  import eth_tx_pkg::*;
#(
  parameter int PREAMBLE_BYTES = 7,
  parameter int IFG_BYTES      = 12,
  parameter int MIN_PAYLOAD    = 46,
  parameter int MAX_PAYLOAD    = 1500,
  parameter int LEN_W          = 11
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic             istart,
  input  logic [LEN_W-1:0] ilen,
  input  logic [47:0]      idaddr,
  input  logic [47:0]      isaddr,
  input  logic [15:0]      ilentype,
  input  logic [7:0]       idata,
  input  logic             idata_valid,
  output logic             odata_ready,
  output logic [7:0]       obyte,
  output logic             ovalid,
  output logic             osof,
  output logic             oeof,
  output logic [3:0]       ost,
  output logic             obusy,
  output logic             oerr_len,
  output logic             ounderrun
);

  eth_st_e          state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d;
  eth_hdr_t         hdr_q, hdr_d;
  logic             bad_q, bad_d;
  logic [7:0]       obyte_q, obyte_d;
  logic             ovalid_q, ovalid_d, osof_q, osof_d, oeof_q, oeof_d;
  logic             obusy_q, obusy_d, oerr_len_q, oerr_len_d, ounderrun_q, ounderrun_d;
  logic             crc_init, crc_en;
  logic [31:0]      crc, fcs;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    len_d       = len_q;
    hdr_d       = hdr_q;
    bad_d       = bad_q;
    oerr_len_d  = 1'b0;
    crc_init    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (istart) begin
          if (ilen > LEN_W'(MAX_PAYLOAD)) oerr_len_d = 1'b1;
          else begin
            state_d  = ST_PREAMBLE;
            len_d    = ilen;
            hdr_d    = '{daddr: idaddr, saddr: isaddr, lentype: ilentype};
            bad_d    = 1'b0;
            crc_init = 1'b1;
          end
        end
      end
      ST_PREAMBLE: if (cnt_q == LEN_W'(PREAMBLE_BYTES - 1)) begin state_d = ST_SFD; cnt_d = '0; end
      ST_SFD:      begin state_d = ST_DADDR; cnt_d = '0; end
      ST_DADDR:    if (cnt_q == LEN_W'(5)) begin state_d = ST_SADDR; cnt_d = '0; end
      ST_SADDR:    if (cnt_q == LEN_W'(5)) begin state_d = ST_LENTYPE; cnt_d = '0; end
      ST_LENTYPE: if (cnt_q == LEN_W'(1)) begin
        cnt_d = '0;
        if (len_q != '0)                      state_d = ST_DATA;
        else if (MIN_PAYLOAD > 0)             state_d = ST_PAD;
        else                                  state_d = ST_FCS;
      end
      // PAD keeps counting from ilen so its end is simply MIN_PAYLOAD-1.
      ST_DATA: if (cnt_q == len_q - 1'b1) begin
        if (len_q < LEN_W'(MIN_PAYLOAD)) state_d = ST_PAD;
        else begin state_d = ST_FCS; cnt_d = '0; end
      end
      ST_PAD:  if (cnt_q == LEN_W'(MIN_PAYLOAD - 1)) begin state_d = ST_FCS; cnt_d = '0; end
      ST_FCS:  if (cnt_q == LEN_W'(FCS_BYTES - 1)) begin state_d = ST_IFG; cnt_d = '0; end
      ST_IFG:  if (cnt_q == LEN_W'(IFG_BYTES - 1)) begin state_d = ST_IDLE; cnt_d = '0; end
      default: begin state_d = ST_IDLE; cnt_d = '0; end
    endcase

    odata_ready = (state_d == ST_DATA) && !irst;
    ounderrun_d = (state_d == ST_DATA) && !idata_valid;
    bad_d       = bad_d | ounderrun_d;
    fcs         = bad_q ? ~crc : crc;
    obyte_d     = 8'h00;
    unique case (state_d)
      ST_PREAMBLE: obyte_d = PREAMBLE_BYTE;
      ST_SFD:      obyte_d = SFD_BYTE;
      ST_DADDR:    obyte_d = hdr_byte(hdr_q, int'(cnt_d));
      ST_SADDR:    obyte_d = hdr_byte(hdr_q, 6 + int'(cnt_d));
      ST_LENTYPE:  obyte_d = hdr_byte(hdr_q, 12 + int'(cnt_d));
      ST_DATA:     obyte_d = idata_valid ? idata : 8'h00;
      ST_FCS:      obyte_d = fcs[8*cnt_d[1:0] +: 8];
      default:     obyte_d = 8'h00;
    endcase
    ovalid_d = (state_d != ST_IDLE) && (state_d != ST_IFG);
    osof_d   = (state_d == ST_PREAMBLE) && (cnt_d == '0);
    oeof_d   = (state_d == ST_FCS) && (cnt_d == LEN_W'(FCS_BYTES - 1));
    obusy_d  = (state_d != ST_IDLE);
    crc_en   = (state_d == ST_DADDR) || (state_d == ST_SADDR) || (state_d == ST_LENTYPE) ||
               (state_d == ST_DATA)  || (state_d == ST_PAD);
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      hdr_q       <= '0;
      bad_q       <= 1'b0;
      obyte_q     <= 8'h00;
      ovalid_q    <= 1'b0;
      osof_q      <= 1'b0;
      oeof_q      <= 1'b0;
      obusy_q     <= 1'b0;
      oerr_len_q  <= 1'b0;
      ounderrun_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      hdr_q       <= hdr_d;
      bad_q       <= bad_d;
      obyte_q     <= obyte_d;
      ovalid_q    <= ovalid_d;
      osof_q      <= osof_d;
      oeof_q      <= oeof_d;
      obusy_q     <= obusy_d;
      oerr_len_q  <= oerr_len_d;
      ounderrun_q <= ounderrun_d;
    end
  end

  eth_crc32_byte u_crc (
    .iclk  (iclk),
    .irst  (irst),
    .iinit (crc_init),
    .ien   (crc_en),
    .idata (obyte_d),
    .ocrc  (crc)
  );

  assign obyte     = obyte_q;
  assign ovalid    = ovalid_q;
  assign osof      = osof_q;
  assign oeof      = oeof_q;
  assign ost       = state_q;
  assign obusy     = obusy_q;
  assign oerr_len  = oerr_len_q;
  assign ounderrun = ounderrun_q;

endmodule

// File: tb/tb_eth_frame_tx_param.sv
// Randomized frame bench with a byte-queue reference model of the transmitted stream.
module tb_eth_frame_tx_param;
  import eth_tx_pkg::*;

  localparam int PRE = 7, IFG = 12, MINP = 46, MAXP = 1500, LW = 11;

  logic          iclk = 1'b0, irst = 1'b1, istart = 1'b0;
  logic [LW-1:0] ilen = '0;
  logic [47:0]   idaddr = '0, isaddr = '0;
  logic [15:0]   ilentype = '0;
  logic [7:0]    idata = '0;
  logic          idata_valid = 1'b0;
  logic          odata_ready, ovalid, osof, oeof, obusy, oerr_len, ounderrun;
  logic [7:0]    obyte;
  logic [3:0]    ost;
  logic          c_init = 1'b0, c_en = 1'b0;
  logic [7:0]    c_data = '0;
  logic [31:0]   c_out;

  always #5 iclk = ~iclk;

  eth_frame_tx_param #(.PREAMBLE_BYTES(PRE), .IFG_BYTES(IFG), .MIN_PAYLOAD(MINP),
                       .MAX_PAYLOAD(MAXP), .LEN_W(LW)) dut (
    .iclk(iclk), .irst(irst), .istart(istart), .ilen(ilen), .idaddr(idaddr),
    .isaddr(isaddr), .ilentype(ilentype), .idata(idata), .idata_valid(idata_valid),
    .odata_ready(odata_ready), .obyte(obyte), .ovalid(ovalid), .osof(osof), .oeof(oeof),
    .ost(ost), .obusy(obusy), .oerr_len(oerr_len), .ounderrun(ounderrun));

  eth_crc32_byte u_crc_ref (.iclk(iclk), .irst(irst), .iinit(c_init), .ien(c_en),
                            .idata(c_data), .ocrc(c_out));

  typedef struct {
    logic [7:0] b;
    logic       sof, eof, ur;
    logic [3:0] st;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       ce;
  int         total = 0, bad = 0;
  logic [7:0] pay[0:2047];
  logic       pm[0:2047];
  int         pidx = 0;
  int         vld_cnt, rdy_cnt, ur_cnt, ifg_cnt, first_v, last_v, cyc = 0;
  bit         seen_eof, chk_on = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] crc32(input logic [7:0] d[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (d[i]) begin
      c ^= {24'h0, d[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic push(input logic [7:0] b, input logic [3:0] st, input logic ur);
    exp_t e;
    e.b = b; e.st = st; e.ur = ur; e.eof = 1'b0;
    e.sof = (exp_q.size() == 0);
    exp_q.push_back(e);
  endtask

  // Whole frame as it must appear on the wire, from the current request inputs.
  task automatic build(input int len);
    logic [7:0]   body[$];
    logic [111:0] h;
    logic [7:0]   b;
    logic [31:0]  c;
    bit           badf = 0;
    h = {idaddr, isaddr, ilentype};
    for (int i = 0; i < PRE; i++) push(8'h55, 4'd1, 1'b0);
    push(8'hD5, 4'd2, 1'b0);
    for (int i = 0; i < 14; i++) begin
      b = h[111-8*i -: 8];
      push(b, (i < 6) ? 4'd3 : (i < 12) ? 4'd4 : 4'd5, 1'b0);
      body.push_back(b);
    end
    for (int i = 0; i < len; i++) begin
      b = pm[i] ? pay[i] : 8'h00;
      if (!pm[i]) badf = 1;
      push(b, 4'd6, !pm[i]);
      body.push_back(b);
    end
    for (int i = len; i < MINP; i++) begin
      push(8'h00, 4'd7, 1'b0);
      body.push_back(8'h00);
    end
    c = crc32(body);
    if (badf) c = ~c;
    for (int i = 0; i < 4; i++) push(c[8*i +: 8], 4'd8, 1'b0);
    exp_q[exp_q.size()-1].eof = 1'b1;
  endtask

  // Payload source: one slot consumed per odata_ready cycle.
  initial begin : feeder
    logic r;
    forever begin
      @(negedge iclk);
      idata = pay[pidx];
      idata_valid = pm[pidx];
      r = odata_ready;
      @(posedge iclk);
      if (r && pidx < 2047) pidx++;
    end
  end

  always @(negedge iclk) begin
    cyc++;
    if (chk_on) begin
      if (ovalid) begin
        vld_cnt++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        if (exp_q.size() == 0) chk("extra_byte", 1, 0);
        else begin
          ce = exp_q.pop_front();
          chk("stream", {obyte, osof, oeof, ost, ounderrun}, {ce.b, ce.sof, ce.eof, ce.st, ce.ur});
        end
        if (oeof) seen_eof = 1;
      end else begin
        chk("idle_out", {obyte, osof, oeof, ounderrun}, 0);
        if (obusy && seen_eof) ifg_cnt++;
      end
      if (odata_ready) rdy_cnt++;
      if (ounderrun) ur_cnt++;
    end
  end

  task automatic start_frame(input int len, input int ur_at, input int exp_total, output int nexp);
    logic [63:0] r64;
    @(posedge iclk); #1;
    r64 = {$urandom, $urandom}; idaddr = r64[47:0];
    r64 = {$urandom, $urandom}; isaddr = r64[47:0];
    ilentype = 16'($urandom_range(0, 65535));
    for (int i = 0; i < 2048; i++) begin
      pay[i] = 8'($urandom_range(0, 255));
      pm[i]  = (i != ur_at);
    end
    pidx = 0;
    exp_q.delete();
    build(len);
    nexp = exp_q.size();
    if (exp_total > 0) chk("model_len", nexp, exp_total);
    vld_cnt = 0; rdy_cnt = 0; ur_cnt = 0; ifg_cnt = 0; first_v = -1; last_v = -1; seen_eof = 0;
    ilen = LW'(len); istart = 1'b1;
    @(posedge iclk); #1;
    istart = 1'b0;
    chk("busy_on", obusy, 1);
    chk("sof_first", {ovalid, osof}, 2'b11);
  endtask

  task automatic run_frame(input int len, input int ur_at, input int exp_total, input bit poke);
    int nexp, n;
    bit poked = 0;
    start_frame(len, ur_at, exp_total, nexp);
    n = 0;
    do begin
      @(negedge iclk);
      n++;
      if (poke && !poked && ost == 4'd9) begin
        istart = 1'b1; ilen = LW'(20); poked = 1;
        @(posedge iclk); #1;
        istart = 1'b0;
      end
    end while (obusy && n < 4000);
    chk("done_in_time", n < 4000, 1);
    repeat (3) @(negedge iclk);
    chk("stays_idle", {obusy, ovalid}, 0);
    chk("vld_len", vld_cnt, nexp);
    chk("contiguous", last_v - first_v + 1, nexp);
    chk("rdy_cnt", rdy_cnt, len);
    chk("ur_cnt", ur_cnt, (ur_at >= 0 && ur_at < len) ? 1 : 0);
    chk("ifg_len", ifg_cnt, IFG);
    chk("q_empty", exp_q.size(), 0);
  endtask

  initial begin : main
    string s;
    logic [7:0] cb[$];
    int nexp, n, len, ur;
    for (int i = 0; i < 2048; i++) begin pay[i] = 8'h00; pm[i] = 1'b1; end
    repeat (3) @(posedge iclk);
    #1 irst = 1'b0;
    chk("reset_out", {obyte, ovalid, osof, oeof, ost, obusy, oerr_len, ounderrun, odata_ready}, 0);
    chk_on = 1;

    s = "123456789";
    for (int i = 0; i < 9; i++) cb.push_back(s[i]);
    chk("model_crc_check", crc32(cb), 32'hCBF43926);
    c_init = 1'b1;
    @(posedge iclk); #1;
    c_init = 1'b0; c_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      c_data = s[i];
      @(posedge iclk); #1;
    end
    c_en = 1'b0;
    chk("crc_unit_check", c_out, 32'hCBF43926);

    run_frame(100, -1, 126, 0);
    run_frame(10, -1, 72, 0);
    run_frame(0, -1, 72, 1);
    run_frame(60, 20, PRE + 1 + 14 + 60 + 4, 0);

    @(posedge iclk); #1;
    ilen = LW'(1501); istart = 1'b1;
    @(posedge iclk); #1;
    istart = 1'b0;
    chk("err_pulse", oerr_len, 1);
    chk("err_stays_idle", {obusy, ovalid, ost}, 0);
    @(posedge iclk); #1;
    chk("err_one_cycle", {oerr_len, obusy, ovalid}, 0);
    run_frame(46, -1, 72, 0);
    run_frame(47, 46, 73, 0);

    start_frame(60, -1, 0, nexp);
    n = 0;
    while (ost != 4'd6 && n < 100) begin @(negedge iclk); n++; end
    chk("reach_data", ost, 6);
    repeat (5) @(negedge iclk);
    @(posedge iclk); #1 irst = 1'b1;
    @(posedge iclk); #1 irst = 1'b0;
    exp_q.delete();
    chk("rst_mid_frame", {ovalid, ost, obusy, odata_ready, obyte}, 0);
    run_frame(30, -1, 72, 0);

    for (int k = 0; k < 8; k++) begin
      len = $urandom_range(0, 120);
      ur  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
      run_frame(len, ur, 0, k[0]);
    end
    run_frame(1500, 777, PRE + 1 + 14 + 1500 + 4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eth_frame_tx_param.md
Name: eth_frame_tx_param

Overview:
Parametrised byte-wide Ethernet frame transmitter; successor to the fixed-length frame FSM in the transmitter path. Accepts a frame request carrying addresses, length/type and payload length, and pulls payload bytes over a valid/ready handshake. Emits a registered byte stream: preamble, SFD, header, payload, zero padding to minimum size, internally computed FCS, then inter-packet gap. Feeds the line-side serialiser.

Parameters:
PREAMBLE_BYTES, 7, number of 0x55 bytes before SFD (1..15)
IFG_BYTES, 12, idle cycles after FCS before next frame (1..255)
MIN_PAYLOAD, 46, payload is zero-padded up to this many bytes
MAX_PAYLOAD, 1500, largest accepted ilen
LEN_W, 11, width of ilen and the internal payload counter

Ports:
iclk  in  1  clock
irst  in  1  synchronous active-high reset
istart  in  1  frame request, sampled only in IDLE
ilen  in  LEN_W  payload length in bytes
idaddr  in  48  destination MAC
isaddr  in  48  source MAC
ilentype  in  16  length/type field
idata  in  8  payload byte
idata_valid  in  1  payload byte available
odata_ready  out  1  block will take idata this cycle
obyte  out  8  transmitted byte
ovalid  out  1  obyte is a frame byte
osof  out  1  first preamble byte marker
oeof  out  1  last FCS byte marker
ost  out  4  state of the byte currently on obyte
obusy  out  1  high from accepted istart through end of IFG
oerr_len  out  1  one-cycle pulse: request rejected, ilen > MAX_PAYLOAD
ounderrun  out  1  one-cycle pulse per substituted payload byte

Behaviour:
- One clock; reset is synchronous and active-high. irst=1 at a posedge clears all outputs to 0 (obyte=0x00, ost=IDLE), CRC to 0xFFFFFFFF, and returns the FSM to IDLE, mid-frame included. No partial frame resumes.
- States (ost): IDLE=0, PREAMBLE=1, SFD=2, DADDR=3, SADDR=4, LENTYPE=5, DATA=6, PAD=7, FCS=8, IFG=9.
- IDLE: istart=1 with ilen<=MAX_PAYLOAD latches ilen/idaddr/isaddr/ilentype and sets obusy. The first preamble byte appears on obyte with ovalid=osof=1 on the following cycle. If ilen>MAX_PAYLOAD: oerr_len pulses one cycle, FSM stays IDLE, obusy stays 0.
- PREAMBLE: PREAMBLE_BYTES x 0x55. SFD: one 0xD5.
- DADDR/SADDR: 6 bytes each, MSB byte first ([47:40] first). LENTYPE: [15:8] then [7:0].
- DATA: entered only if ilen>0, else LENTYPE goes straight to PAD. odata_ready=1 in every DATA cycle and 0 elsewhere. idata_valid&odata_ready transfers idata, which appears on obyte the next cycle. If idata_valid=0 in a DATA cycle: 0x00 is sent instead, ounderrun pulses, the byte still counts toward ilen, and the frame is marked bad. The line never stalls.
- PAD: (MIN_PAYLOAD - ilen) bytes of 0x00 when ilen<MIN_PAYLOAD, otherwise skipped.
- FCS: 4 bytes, crc[7:0] first. oeof=1 with the 4th byte. If the frame is marked bad, the FCS is bit-inverted.
- IFG: IFG_BYTES cycles with ovalid=0 and obyte=0x00, then IDLE with obusy=0. istart is ignored while obusy=1.
- CRC: IEEE 802.3 CRC-32, reflected poly 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF. Covers DADDR through PAD bytes as transmitted. Reinitialised at each istart accept.
- ovalid=1 for exactly PREAMBLE_BYTES+1+14+max(ilen,MIN_PAYLOAD)+4 consecutive cycles per frame, with no gaps.
- Counters are LEN_W bits wide and never wrap within legal ilen.

Decomposition:
- Package eth_tx_pkg: state enum (4-bit), PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, CRC_POLY_REFL=32'hEDB88320, CRC_INIT=32'hFFFFFFFF, header byte count 14, FCS byte count 4.
- Sub-module eth_crc32_byte: inputs iclk, irst, iinit, ien, idata[7:0]; output ocrc[31:0] (final-XORed). One byte per enabled cycle.

Test Plan:
- eth_crc32_byte fed ASCII "123456789" -> ocrc=0xCBF43926.
- Defaults, ilen=100, payload 0x00..0x63 always valid -> 126 contiguous ovalid cycles. Bytes: 7x55, D5, header, payload, FCS. FCS matches the reference model; osof on cycle 1, oeof on cycle 126, then 12 idle cycles before obusy=0.
- ilen=10 -> 10 payload bytes plus 36 0x00 pad bytes, 72 ovalid cycles, odata_ready high exactly 10 cycles. ilen=0 -> no odata_ready, 46 pad bytes, 72 ovalid cycles.
- ilen=1501 -> oerr_len one pulse, ovalid stays 0, obusy stays 0. A following istart with ilen=46 is accepted normally.
- ilen=60, idata_valid dropped on payload byte 20 -> that obyte=0x00, ounderrun pulses once, frame length unchanged, FCS equals the bitwise inverse of the good CRC.
- irst asserted during DATA of frame 1 -> next cycle ovalid=0 and ost=IDLE. A new istart then yields a complete correct frame. istart pulsed during IFG -> ignored.
